// File: rtl/fp_vector_bist_if.sv
// Vector-RAM read port and add/mul DUT drive/result signals of the BIST engine.
// master = BIST engine side, slave = RAM + DUT side.
interface fp_vector_bist_if #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned ADDR_W      = 8
);
    logic                   vec_rd;
    logic [ADDR_W-1:0]      vec_addr;
    logic [WORD_LENGTH-1:0] vec_a;
    logic [WORD_LENGTH-1:0] vec_b;
    logic [WORD_LENGTH-1:0] exp_add;
    logic [WORD_LENGTH-1:0] exp_mul;
    logic                   dut_mode;
    logic [WORD_LENGTH-1:0] dut_a;
    logic [WORD_LENGTH-1:0] dut_b;
    logic [WORD_LENGTH-1:0] dut_add;
    logic [WORD_LENGTH-1:0] dut_mul;
    logic                   dut_mul_error;

    modport master (
        output vec_rd, vec_addr, dut_mode, dut_a, dut_b,
        input  vec_a, vec_b, exp_add, exp_mul, dut_add, dut_mul, dut_mul_error
    );

    modport slave (
        input  vec_rd, vec_addr, dut_mode, dut_a, dut_b,
        output vec_a, vec_b, exp_add, exp_mul, dut_add, dut_mul, dut_mul_error
    );
endinterface

// File: rtl/fp_vector_bist.sv
// Pipelined self-checking vector engine for the int/fp16 add and mul units:
// streams vectors from a sync-read RAM, drives the DUTs one per cycle, counts mismatches.
module fp_vector_bist #(
    parameter int unsigned EXP_W       = 5,
    parameter int unsigned MAN_W       = 10,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned DUT_LATENCY = 4,
    parameter int unsigned CNT_W       = 16,
    parameter bit          NAN_EQ      = 1'b1,
    localparam int unsigned WORD_LENGTH = 1 + EXP_W + MAN_W,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_mode_in,
    input  logic [ADDR_W:0]   i_num_vec,
    fp_vector_bist_if.master  bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_aborted,
    output logic [CNT_W-1:0]  o_err_add_cnt,
    output logic [CNT_W-1:0]  o_err_mul_cnt,
    output logic [CNT_W-1:0]  o_mul_flag_cnt,
    output logic [ADDR_W-1:0] o_first_fail,
    output logic              o_fail_seen
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_vec_rd;
    logic [ADDR_W-1:0]      r_vec_addr;
    logic                   r_mode;
    logic [ADDR_W:0]        r_num;
    logic [WORD_LENGTH-1:0] r_dut_a;
    logic [WORD_LENGTH-1:0] r_dut_b;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_aborted;
    logic [CNT_W-1:0]       r_err_add_cnt;
    logic [CNT_W-1:0]       r_err_mul_cnt;
    logic [CNT_W-1:0]       r_mul_flag_cnt;
    logic [ADDR_W-1:0]      r_first_fail;
    logic                   r_fail_seen;

    // RAM-read stage, then 1+DUT_LATENCY stages of expected values aligned to DUT output
    logic                   r_p1_vld;
    logic                   r_p1_last;
    logic [ADDR_W-1:0]      r_p1_idx;
    logic                   r_sh_vld  [DUT_LATENCY+1];
    logic                   r_sh_last [DUT_LATENCY+1];
    logic [ADDR_W-1:0]      r_sh_idx  [DUT_LATENCY+1];
    logic [WORD_LENGTH-1:0] r_sh_add  [DUT_LATENCY+1];
    logic [WORD_LENGTH-1:0] r_sh_mul  [DUT_LATENCY+1];

    logic w_flush;
    logic w_last_addr;
    logic w_chk;
    logic w_add_mis;
    logic w_mul_mis;
    logic w_any_mis;
    logic w_final;

    function automatic logic f_is_nan(input logic [WORD_LENGTH-1:0] x);
        return (&x[WORD_LENGTH-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic f_match(input logic [WORD_LENGTH-1:0] e,
                                     input logic [WORD_LENGTH-1:0] a,
                                     input logic                   fp);
        return (e == a) || (NAN_EQ && fp && f_is_nan(e) && f_is_nan(a));
    endfunction

    assign w_flush     = i_abort && r_busy;
    assign w_last_addr = ({1'b0, r_vec_addr} == (r_num - 1'b1));
    assign w_chk       = r_sh_vld[DUT_LATENCY];
    assign w_add_mis   = w_chk && !f_match(r_sh_add[DUT_LATENCY], bus.dut_add, r_mode);
    assign w_mul_mis   = w_chk && !f_match(r_sh_mul[DUT_LATENCY], bus.dut_mul, r_mode);
    assign w_any_mis   = w_add_mis || w_mul_mis;
    assign w_final     = w_chk && r_sh_last[DUT_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p1_vld  <= 1'b0;
            r_p1_last <= 1'b0;
            r_p1_idx  <= '0;
            r_dut_a   <= '0;
            r_dut_b   <= '0;
            for (int unsigned k = 0; k <= DUT_LATENCY; k++) begin
                r_sh_vld[k]  <= 1'b0;
                r_sh_last[k] <= 1'b0;
                r_sh_idx[k]  <= '0;
                r_sh_add[k]  <= '0;
                r_sh_mul[k]  <= '0;
            end
        end else begin
            r_p1_vld  <= r_vec_rd && !w_flush;
            r_p1_last <= w_last_addr;
            r_p1_idx  <= r_vec_addr;
            // DUT operands only move on real vectors so they hold between and after runs
            if (r_p1_vld) begin
                r_dut_a <= bus.vec_a;
                r_dut_b <= bus.vec_b;
            end
            r_sh_vld[0]  <= r_p1_vld && !w_flush;
            r_sh_last[0] <= r_p1_last;
            r_sh_idx[0]  <= r_p1_idx;
            r_sh_add[0]  <= bus.exp_add;
            r_sh_mul[0]  <= bus.exp_mul;
            for (int unsigned k = 1; k <= DUT_LATENCY; k++) begin
                r_sh_vld[k]  <= r_sh_vld[k-1] && !w_flush;
                r_sh_last[k] <= r_sh_last[k-1];
                r_sh_idx[k]  <= r_sh_idx[k-1];
                r_sh_add[k]  <= r_sh_add[k-1];
                r_sh_mul[k]  <= r_sh_mul[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_vec_rd       <= 1'b0;
            r_vec_addr     <= '0;
            r_mode         <= 1'b0;
            r_num          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_aborted      <= 1'b0;
            r_err_add_cnt  <= '0;
            r_err_mul_cnt  <= '0;
            r_mul_flag_cnt <= '0;
            r_first_fail   <= '0;
            r_fail_seen    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_mode         <= i_mode_in;
                        r_num          <= i_num_vec;
                        r_aborted      <= 1'b0;
                        r_err_add_cnt  <= '0;
                        r_err_mul_cnt  <= '0;
                        r_mul_flag_cnt <= '0;
                        r_first_fail   <= '0;
                        r_fail_seen    <= 1'b0;
                        r_vec_addr     <= '0;
                        if (i_num_vec == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state  <= S_ISSUE;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                            r_pass   <= 1'b0;
                            r_vec_rd <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_abort) begin
                        r_state   <= S_DONE;
                        r_vec_rd  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        if (r_state == S_ISSUE) begin
                            if (w_last_addr) begin
                                r_vec_rd <= 1'b0;
                                r_state  <= S_DRAIN;
                            end else begin
                                r_vec_addr <= r_vec_addr + 1'b1;
                            end
                        end
                        if (w_add_mis && (r_err_add_cnt != '1))
                            r_err_add_cnt <= r_err_add_cnt + 1'b1;
                        if (w_mul_mis && (r_err_mul_cnt != '1))
                            r_err_mul_cnt <= r_err_mul_cnt + 1'b1;
                        if (w_chk && bus.dut_mul_error && (r_mul_flag_cnt != '1))
                            r_mul_flag_cnt <= r_mul_flag_cnt + 1'b1;
                        if (w_any_mis && !r_fail_seen) begin
                            r_first_fail <= r_sh_idx[DUT_LATENCY];
                            r_fail_seen  <= 1'b1;
                        end
                        // Final compare's own result folds into pass in the same edge
                        if (w_final) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_add_cnt == '0) && (r_err_mul_cnt == '0) && !w_any_mis;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.vec_rd     = r_vec_rd;
    assign bus.vec_addr   = r_vec_addr;
    assign bus.dut_mode   = r_mode;
    assign bus.dut_a      = r_dut_a;
    assign bus.dut_b      = r_dut_b;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_pass         = r_pass;
    assign o_aborted      = r_aborted;
    assign o_err_add_cnt  = r_err_add_cnt;
    assign o_err_mul_cnt  = r_err_mul_cnt;
    assign o_mul_flag_cnt = r_mul_flag_cnt;
    assign o_first_fail   = r_first_fail;
    assign o_fail_seen    = r_fail_seen;

endmodule

// File: tb/tb_fp_vector_bist.sv
// Scoreboard bench for fp_vector_bist: vector RAM and pipelined add/mul DUT models,
// per-run expected summary pushed at start and checked when done rises.
module tb_fp_vector_bist;

    localparam int LAT   = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    typedef struct {
        int unsigned done_cyc;
        bit          pass;
        bit          aborted;
        bit          fail_seen;
        int unsigned add_cnt;
        int unsigned mul_cnt;
        int unsigned flag_cnt;
        int unsigned ff;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode_in = 1'b0;
    logic [AW:0]   num_vec = '0;
    logic          o_busy, o_done, o_pass, o_aborted, o_fail_seen;
    logic [CW-1:0] o_err_add_cnt, o_err_mul_cnt, o_mul_flag_cnt;
    logic [AW-1:0] o_first_fail;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sbq[$];
    bit          prev_done = 1'b0;

    logic [15:0] mem_a[DEPTH], mem_b[DEPTH], mem_add[DEPTH], mem_mul[DEPTH];
    logic [15:0] pl_add[LAT], pl_mul[LAT];
    logic        pl_err[LAT];

    fp_vector_bist_if #(.WORD_LENGTH(16), .ADDR_W(AW)) bus ();

    fp_vector_bist #(
        .EXP_W(5), .MAN_W(10), .DEPTH(DEPTH), .DUT_LATENCY(LAT), .CNT_W(CW), .NAN_EQ(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_mode_in(mode_in), .i_num_vec(num_vec), .bus(bus),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_aborted(o_aborted),
        .o_err_add_cnt(o_err_add_cnt), .o_err_mul_cnt(o_err_mul_cnt),
        .o_mul_flag_cnt(o_mul_flag_cnt), .o_first_fail(o_first_fail), .o_fail_seen(o_fail_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        if (a == 16'hDEAD) return 16'h7C01;
        p = a * b;
        return p[15:0];
    endfunction

    function automatic logic m_flag(input logic [15:0] a, input logic [15:0] b);
        return a[0] ^ b[0];
    endfunction

    function automatic bit is_nan16(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic bit ref_eq(input logic [15:0] e, input logic [15:0] a, input bit fp);
        return (e == a) || (fp && is_nan16(e) && is_nan16(a));
    endfunction

    // Vector RAM (sync read) and golden add/mul units with LAT register stages
    always @(posedge clk) begin
        if (bus.vec_rd) begin
            bus.vec_a   <= mem_a[bus.vec_addr];
            bus.vec_b   <= mem_b[bus.vec_addr];
            bus.exp_add <= mem_add[bus.vec_addr];
            bus.exp_mul <= mem_mul[bus.vec_addr];
        end
        pl_add[0] <= m_add(bus.dut_a, bus.dut_b);
        pl_mul[0] <= m_mul(bus.dut_a, bus.dut_b);
        pl_err[0] <= m_flag(bus.dut_a, bus.dut_b);
        for (int k = 1; k < LAT; k++) begin
            pl_add[k] <= pl_add[k-1];
            pl_mul[k] <= pl_mul[k-1];
            pl_err[k] <= pl_err[k-1];
        end
    end
    assign bus.dut_add       = pl_add[LAT-1];
    assign bus.dut_mul       = pl_mul[LAT-1];
    assign bus.dut_mul_error = pl_err[LAT-1];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic exp_t ref_run(input int n, input bit fp);
        exp_t        e;
        int unsigned ea, em, ef;
        bit          add_bad, mul_bad;
        e  = '{default: 0};
        ea = 0; em = 0; ef = 0;
        for (int i = 0; i < n; i++) begin
            add_bad = !ref_eq(mem_add[i], m_add(mem_a[i], mem_b[i]), fp);
            mul_bad = !ref_eq(mem_mul[i], m_mul(mem_a[i], mem_b[i]), fp);
            if (add_bad) ea++;
            if (mul_bad) em++;
            if (m_flag(mem_a[i], mem_b[i])) ef++;
            if ((add_bad || mul_bad) && !e.fail_seen) begin
                e.fail_seen = 1'b1;
                e.ff        = i;
            end
        end
        e.add_cnt  = (ea > MAXC) ? MAXC : ea;
        e.mul_cnt  = (em > MAXC) ? MAXC : em;
        e.flag_cnt = (ef > MAXC) ? MAXC : ef;
        e.pass     = (ea == 0) && (em == 0);
        return e;
    endfunction

    task automatic fill_golden(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            mem_a[i] = (r[15:0] == 16'hDEAD) ? 16'hBEEF : r[15:0];
            mem_b[i] = r[31:16];
            mem_add[i] = m_add(mem_a[i], mem_b[i]);
            mem_mul[i] = m_mul(mem_a[i], mem_b[i]);
        end
    endtask

    task automatic corrupt_random(input int n);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = $urandom_range(1, 1023);
            case ($urandom_range(0, 7))
                0: mem_add[i] = mem_add[i] ^ 16'h0100;
                1: mem_mul[i] = mem_mul[i] ^ 16'h0010;
                2: begin
                    mem_add[i] = mem_add[i] ^ 16'h8000;
                    mem_mul[i] = mem_mul[i] ^ 16'h0001;
                end
                3: begin
                    mem_a[i]   = 16'hDEAD;
                    mem_add[i] = m_add(mem_a[i], mem_b[i]);
                    mem_mul[i] = {t[10], 5'h1F, t[9:0]};
                end
                default: ;
            endcase
        end
    endtask

    // ab > 0: abort sampled ab edges after the start edge
    task automatic run(input int n, input bit fp, input int ab);
        exp_t e;
        if (ab > 0) begin
            e = '{default: 0};
            e.aborted = 1'b1;
        end else begin
            e = ref_run(n, fp);
        end
        @(posedge clk); #1;
        e.done_cyc = cyc + 1 + ((n == 0) ? 0 : ((ab > 0) ? ab : n + 2 + LAT));
        num_vec = n[AW:0];
        mode_in = fp;
        start   = 1'b1;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", o_busy, (n > 0) ? 1 : 0);
        if (n > 0) begin
            start   = 1'b1;
            num_vec = '0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (ab > 0) begin
            repeat (ab - 2) begin
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        for (int k = 0; k < n + 2 * LAT + 20 && sbq.size() != 0; k++) @(posedge clk);
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: done never rose for n=%0d, got busy=%0d expected done=1", n, o_busy);
            sbq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (o_done && !prev_done) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no run pending");
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_at_done", o_busy, 0);
                    chk("pass", o_pass, e.pass);
                    chk("aborted", o_aborted, e.aborted);
                    chk("err_add_cnt", o_err_add_cnt, e.add_cnt);
                    chk("err_mul_cnt", o_err_mul_cnt, e.mul_cnt);
                    chk("mul_flag_cnt", o_mul_flag_cnt, e.flag_cnt);
                    chk("fail_seen", o_fail_seen, e.fail_seen);
                    if (e.fail_seen) chk("first_fail", o_first_fail, e.ff);
                end
            end
            prev_done = o_done;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_pass"}, o_pass, 0);
        chk({tag, "_aborted"}, o_aborted, 0);
        chk({tag, "_err_add"}, o_err_add_cnt, 0);
        chk({tag, "_err_mul"}, o_err_mul_cnt, 0);
        chk({tag, "_flag_cnt"}, o_mul_flag_cnt, 0);
        chk({tag, "_first_fail"}, o_first_fail, 0);
        chk({tag, "_fail_seen"}, o_fail_seen, 0);
        chk({tag, "_vec_rd"}, bus.vec_rd, 0);
        chk({tag, "_vec_addr"}, bus.vec_addr, 0);
        chk({tag, "_dut_a"}, bus.dut_a, 0);
        chk({tag, "_dut_b"}, bus.dut_b, 0);
        chk({tag, "_dut_mode"}, bus.dut_mode, 0);
    endtask

    initial begin
        int n;
        bit fpm;

        @(posedge clk); #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run(0, 1'b1, 0);

        fill_golden(4);
        run(4, 1'b1, 0);

        fill_golden(8);
        mem_a[5]   = 16'h3C00;
        mem_b[5]   = 16'h0000;
        mem_add[5] = 16'h3C01;
        mem_mul[5] = m_mul(16'h3C00, 16'h0000);
        run(8, 1'b1, 0);

        fill_golden(3);
        mem_a[1]   = 16'hDEAD;
        mem_add[1] = m_add(mem_a[1], mem_b[1]);
        mem_mul[1] = 16'h7E00;
        run(3, 1'b1, 0);
        run(3, 1'b0, 0);

        fill_golden(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            mem_add[i] = mem_add[i] + 16'd1;
            mem_mul[i] = mem_mul[i] ^ 16'h0004;
        end
        run(DEPTH, 1'b1, 0);

        fill_golden(DEPTH);
        run(DEPTH, 1'b1, 3);

        repeat (6) begin
            n   = $urandom_range(1, DEPTH);
            fpm = 1'($urandom_range(0, 1));
            fill_golden(n);
            corrupt_random(n);
            run(n, fpm, 0);
        end

        fill_golden(20);
        @(posedge clk); #1;
        num_vec = 7'd20;
        mode_in = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        fill_golden(4);
        run(4, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
